// File: rtl/g10_tx_gearbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gtype (package)
//  Description : Shared types and constants for the 10G transmit gearbox.
//                blk66_t is laid out so that a cast of {data, hdr} puts the
//                sync header in the two least-significant bits, which are
//                serialised first.
//  Revision    : 1.0 - initial release
// ============================================================================
package gtype;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  hdr;
    } blk66_t;

    localparam logic [1:0] SH_DATA   = 2'b01;
    localparam logic [1:0] SH_CTRL   = 2'b10;
    localparam int         GB_PERIOD = 33;

endpackage
`default_nettype wire

// File: rtl/g10_tx_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : g10_tx_gearbox
//  Description : 66b -> 32b transmit gearbox. Blocks {blk_data, blk_hdr} are
//                appended to a 97-bit bit buffer at position fill whenever
//                fill < 32; every running cycle the low 32 bits are
//                registered to pma_tx and the buffer shifts right by 32.
//                Missing blocks are replaced by an all-zero data block and
//                counted as underflows.
//  Ports       : clk           - PMA transmit clock
//                rst           - asynchronous active-high reset
//                pma_tx_rdy    - transceiver ready; gearbox idles when low
//                blk_data/hdr  - 66-bit block payload and sync header
//                blk_valid     - block offered
//                blk_ready     - block accepted this cycle (registered state)
//                pma_tx        - 32-bit word to transceiver, bit 0 first
//                underflow     - sticky underflow flag
//                underflow_cnt - saturating underflow event count
//  Revision    : 1.0 - initial release
// ============================================================================
module g10_tx_gearbox
    import gtype::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pma_tx_rdy,
    input  logic [63:0]       blk_data,
    input  logic [1:0]        blk_hdr,
    input  logic              blk_valid,
    output logic              blk_ready,
    output logic [WORD_W-1:0] pma_tx,
    output logic              underflow,
    output logic [CNT_W-1:0]  underflow_cnt
);

    localparam int c_BLK_W = 66;
    localparam int c_BUF_W = 97;  // 31 leftover bits + one 66-bit block

    logic [c_BUF_W-1:0] r_buf;
    logic [6:0]         r_fill;
    logic [WORD_W-1:0]  r_pma_tx;
    logic               r_underflow;
    logic [CNT_W-1:0]   r_underflow_cnt;

    logic               w_take;
    blk66_t             w_blk;
    logic [c_BUF_W-1:0] w_app;
    logic [c_BUF_W-1:0] w_buf;

    // Ready depends only on registered fill and the PMA ready level, so an
    // upstream valid can never loop back into ready.
    assign w_take    = pma_tx_rdy & ~rst & (r_fill < 7'(WORD_W));
    assign blk_ready = w_take;

    // A slot that is granted but not filled by upstream carries a filler block.
    assign w_blk = blk_valid ? blk66_t'({blk_data, blk_hdr})
                             : blk66_t'({64'h0, SH_DATA});

    // Bits at or above fill are always zero, so OR-ing places the new block
    // directly behind the leftover bits.
    assign w_app = {{(c_BUF_W - c_BLK_W){1'b0}}, w_blk} << r_fill;
    assign w_buf = w_take ? (r_buf | w_app) : r_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf    <= '0;
            r_fill   <= '0;
            r_pma_tx <= '0;
        end else if (!pma_tx_rdy) begin
            r_buf    <= '0;
            r_fill   <= '0;
            r_pma_tx <= '0;
        end else begin
            r_pma_tx <= w_buf[WORD_W-1:0];
            r_buf    <= w_buf >> WORD_W;
            r_fill   <= w_take ? r_fill + 7'(c_BLK_W - WORD_W)
                               : r_fill - 7'(WORD_W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
        end else if (w_take && !blk_valid) begin
            r_underflow <= 1'b1;
            if (r_underflow_cnt != {CNT_W{1'b1}}) begin
                r_underflow_cnt <= r_underflow_cnt + 1'b1;
            end
        end
    end

    assign pma_tx        = r_pma_tx;
    assign underflow     = r_underflow;
    assign underflow_cnt = r_underflow_cnt;

endmodule
`default_nettype wire

// File: tb/tb_g10_tx_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_g10_tx_gearbox
//  Description : Self-checking bench for g10_tx_gearbox. A hand-computed
//                vector table covers alignment and filler insertion; a
//                bit-queue model checks long sequences, ready gaps and
//                underflow counting. A second instance with a 4-bit counter
//                exercises counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_g10_tx_gearbox;
    import gtype::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pma_tx_rdy;
    logic [63:0] blk_data;
    logic [1:0]  blk_hdr;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] pma_tx;
    logic        underflow;
    logic [15:0] underflow_cnt;

    logic        rdy2;
    logic        valid2;
    logic        ready2;
    logic [31:0] tx2;
    logic        uf2;
    logic [3:0]  cnt2;

    always #5 clk = ~clk;

    g10_tx_gearbox #(.WORD_W(32), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .pma_tx_rdy    (pma_tx_rdy),
        .blk_data      (blk_data),
        .blk_hdr       (blk_hdr),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .pma_tx        (pma_tx),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    g10_tx_gearbox #(.WORD_W(32), .CNT_W(4)) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .pma_tx_rdy    (rdy2),
        .blk_data      (64'h0),
        .blk_hdr       (SH_DATA),
        .blk_valid     (valid2),
        .blk_ready     (ready2),
        .pma_tx        (tx2),
        .underflow     (uf2),
        .underflow_cnt (cnt2)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_acc  = 0;

    // Reference model: queue of bits still to be transmitted, bit 0 at front.
    bit          q[$];
    int          m_cnt;
    bit          m_uf;

    typedef struct {
        bit          rdy;
        bit          vld;
        logic [1:0]  hdr;
        logic [63:0] data;
        bit          e_rdy;
        logic [31:0] e_tx;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pma_tx_rdy = 1'b0; blk_valid = 1'b0; rdy2 = 1'b0; valid2 = 1'b0;
        blk_data = '0; blk_hdr = SH_DATA;
        #1;
        chk("rst_pma_tx", pma_tx, 32'h0);
        chk("rst_ready", blk_ready, 1'b0);
        chk("rst_uf", underflow, 1'b0);
        chk("rst_cnt", underflow_cnt, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        q.delete(); m_cnt = 0; m_uf = 0;
    endtask

    // One clock of stimulus checked against the bit-queue model.
    task automatic step(input bit rdy, input bit vld, input logic [63:0] d, input logic [1:0] h);
        bit          er;
        logic [31:0] ew;
        blk66_t      b;
        @(negedge clk);
        pma_tx_rdy = rdy; blk_valid = vld; blk_data = d; blk_hdr = h;
        #1;
        er = rdy && (q.size() < 32);
        chk("blk_ready", blk_ready, er);
        ew = '0;
        if (!rdy) begin
            q.delete();
        end else begin
            if (er) begin
                n_acc++;
                b = vld ? blk66_t'({d, h}) : blk66_t'({64'h0, SH_DATA});
                if (!vld) begin
                    m_uf = 1;
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end
                for (int i = 0; i < 66; i++) q.push_back(b[i]);
            end
            for (int i = 0; i < 32; i++) ew[i] = q.pop_front();
        end
        @(posedge clk);
        #1;
        chk("pma_tx", pma_tx, ew);
        chk("underflow", underflow, m_uf);
        chk("underflow_cnt", underflow_cnt, m_cnt[15:0]);
    endtask

    initial begin
        int slots;

        // Hand-computed alignment sequence starting from fill = 0.
        vecs[0] = '{1, 1, SH_CTRL, 64'hFFFF_FFFF_FFFF_FFFF, 1, 32'hFFFF_FFFE, 16'd0};
        vecs[1] = '{1, 1, SH_DATA, 64'h0,                   0, 32'hFFFF_FFFF, 16'd0};
        vecs[2] = '{1, 1, SH_DATA, 64'h0123_4567_89AB_CDEF, 1, 32'h9ABC_DEF7, 16'd0};
        vecs[3] = '{1, 1, SH_DATA, 64'h5555_5555_5555_5555, 0, 32'h1234_5678, 16'd0};
        vecs[4] = '{1, 0, SH_DATA, 64'h0,                   1, 32'h0000_0010, 16'd1};
        vecs[5] = '{0, 1, SH_DATA, 64'h0,                   0, 32'h0000_0000, 16'd1};
        vecs[6] = '{1, 1, SH_CTRL, 64'hFFFF_FFFF_FFFF_FFFF, 1, 32'hFFFF_FFFE, 16'd1};

        rst = 1'b1; pma_tx_rdy = 1'b0; blk_valid = 1'b0; blk_data = '0; blk_hdr = SH_DATA;
        rdy2 = 1'b0; valid2 = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            pma_tx_rdy = vecs[i].rdy; blk_valid = vecs[i].vld;
            blk_data = vecs[i].data; blk_hdr = vecs[i].hdr;
            #1;
            chk($sformatf("vec%0d_ready", i), blk_ready, vecs[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_tx", i), pma_tx, vecs[i].e_tx);
            chk($sformatf("vec%0d_cnt", i), underflow_cnt, vecs[i].e_cnt);
            chk($sformatf("vec%0d_uf", i), underflow, vecs[i].e_cnt != 0);
        end

        // Steady state: 16 blocks per 33 cycles with valid held high.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 33; i++) step(1, 1, 64'(i + 1), SH_DATA);
        chk("accepts_per_33", n_acc, 16);
        n_acc = 0;
        for (int i = 0; i < 33; i++) step(1, 1, 64'(i + 100), SH_CTRL);
        chk("accepts_per_33_b", n_acc, 16);

        // Random payloads with valid always high: stream exact, no underflow.
        for (int i = 0; i < 1500; i++)
            step(1, 1, {$urandom, $urandom}, $urandom_range(0, 1) ? SH_DATA : SH_CTRL);
        chk("no_underflow_cnt", underflow_cnt, 16'h0);
        chk("no_underflow_flag", underflow, 1'b0);

        // Withhold valid for exactly three granted slots.
        slots = 0;
        for (int i = 0; i < 20 && slots < 3; i++) begin
            if (q.size() < 32) slots++;
            step(1, 0, 64'hDEAD_BEEF_0000_0001, SH_CTRL);
        end
        for (int i = 0; i < 10; i++) step(1, 1, {$urandom, $urandom}, SH_DATA);
        chk("uf3_cnt", underflow_cnt, 16'd3);
        chk("uf3_flag", underflow, 1'b1);

        // Ready gap of five cycles mid-stream, then restart at fill 0.
        for (int i = 0; i < 5; i++) step(0, 1, 64'h1234, SH_DATA);
        chk("gap_cnt_held", underflow_cnt, 16'd3);
        step(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, SH_CTRL);
        chk("restart_word", pma_tx, 32'hFFFF_FFFE);
        for (int i = 0; i < 40; i++) step(1, 1, {$urandom, $urandom}, SH_DATA);

        // Reset in the middle of a block discards buffered bits.
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, {$urandom, $urandom}, SH_CTRL);

        // Counter saturation on the 4-bit instance.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            rdy2 = 1'b1; valid2 = 1'b0;
            if (i == 20) chk("sat_cnt_mid", cnt2, 4'd10);
        end
        @(negedge clk);
        chk("sat_cnt", cnt2, 4'hF);
        chk("sat_flag", uf2, 1'b1);
        rdy2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
